// File: rtl/lfsr_prng_seg_if.sv
// rtl/lfsr_prng_seg_if.sv - control and result bundle for the LFSR PRNG with hex display
interface lfsr_prng_seg_if #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 4
);
    logic              run;
    logic              step;
    logic              seed_load;
    logic [WIDTH-1:0]  seed_in;
    logic [WIDTH-1:0]  rand_out;
    logic              rand_valid;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_sel;
    logic              wrap_flag;

    modport master (
        output run, step, seed_load, seed_in,
        input  rand_out, rand_valid, seg, dig_sel, wrap_flag
    );

    modport slave (
        input  run, step, seed_load, seed_in,
        output rand_out, rand_valid, seg, dig_sel, wrap_flag
    );
endinterface

// File: rtl/lfsr_prng_seg.sv
// rtl/lfsr_prng_seg.sv - Galois LFSR PRNG with multiplexed hex 7-segment driver; optional wrap detection under PRNG_WRAP_DET_EN
module lfsr_prng_seg #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
    parameter int               DIGITS   = 4,
    parameter int               TICK_DIV = 10,
    parameter int               SCAN_DIV = 4
) (
    input logic              clk,
    input logic              rst_n,
    input logic              ena,
    lfsr_prng_seg_if.slave   bus
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    // A zero state would lock the LFSR, so a zero seed is promoted to 1.
    localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [PW-1:0]     pre_q;
    logic              step_q;
    logic [WIDTH-1:0]  state_q;
    logic              valid_q;
    logic [SW-1:0]     scan_q;
    logic [IW-1:0]     idx_q;
    logic [6:0]        seg_q;
    logic [DIGITS-1:0] dig_q;

    logic              tick;
    logic              step_rise;
    logic              load;
    logic              advance;
    logic [WIDTH-1:0]  load_val;
    logic [WIDTH-1:0]  next_state;
    logic [WIDTH-1:0]  shifted;
    logic [3:0]        nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // Advance/load decode: a load beats any advance, and tick plus step edge advance only once.
    always_comb begin
        tick       = ena & bus.run & (pre_q == PW'(TICK_DIV - 1));
        step_rise  = bus.step & ~step_q;
        load       = ena & bus.seed_load;
        advance    = ena & ~load & (tick | step_rise);
        load_val   = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
        next_state = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
        shifted    = state_q >> {idx_q, 2'b00};
        nibble     = shifted[3:0];
    end

    // Free-running step prescaler, frozen unless enabled and running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (ena && bus.run) begin
            pre_q <= tick ? '0 : pre_q + PW'(1);
        end
    end

    // Step edge register keeps tracking while disabled so a held step cannot fire on enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= 1'b0;
        end else begin
            step_q <= bus.step;
        end
    end

    // LFSR state and one-cycle valid pulse on each advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED_NZ;
            valid_q <= 1'b0;
        end else begin
            valid_q <= advance;
            if (load) begin
                state_q <= load_val;
            end else if (advance) begin
                state_q <= next_state;
            end
        end
    end

    // Digit scan counter and digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_q <= '0;
            idx_q  <= '0;
        end else if (ena) begin
            if (scan_q == SW'(SCAN_DIV - 1)) begin
                scan_q <= '0;
                idx_q  <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
            end else begin
                scan_q <= scan_q + SW'(1);
            end
        end
    end

    // Registered segment and digit-select drive; blank while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            dig_q <= '0;
        end else if (ena) begin
            seg_q <= hex7(nibble);
            dig_q <= DIGITS'(1) << idx_q;
        end else begin
            seg_q <= '0;
            dig_q <= '0;
        end
    end

`ifdef PRNG_WRAP_DET_EN
    logic [WIDTH-1:0] seed_q;
    logic             wrap_q;

    // Remember the last seed and flag when the sequence returns to it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q <= SEED_NZ;
            wrap_q <= 1'b0;
        end else if (load) begin
            seed_q <= load_val;
            wrap_q <= 1'b0;
        end else if (advance && (next_state == seed_q)) begin
            wrap_q <= 1'b1;
        end
    end

    assign bus.wrap_flag = wrap_q;
`else
    assign bus.wrap_flag = 1'b0;
`endif

    assign bus.rand_out   = state_q;
    assign bus.rand_valid = valid_q;
    assign bus.seg        = seg_q;
    assign bus.dig_sel    = dig_q;
endmodule

// File: tb/tb_lfsr_prng_seg.sv
// tb/tb_lfsr_prng_seg.sv - self-checking bench for lfsr_prng_seg
module tb_lfsr_prng_seg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic ena_s = 1'b0;

    always #5 clk = ~clk;

    lfsr_prng_seg_if #(.WIDTH(16), .DIGITS(4)) bus ();
    lfsr_prng_seg_if #(.WIDTH(4), .DIGITS(1)) sbus ();

    lfsr_prng_seg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus.slave)
    );

    lfsr_prng_seg #(
        .WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .DIGITS(1), .TICK_DIV(1), .SCAN_DIV(4)
    ) sdut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena_s),
        .bus   (sbus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the default-parameter instance.
    int hex_tab[16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                        'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};

    function automatic int lfsr_step(input int s);
        if (s % 2 == 1) return (s / 2) ^ 'hB400;
        return s / 2;
    endfunction

    int m_state, m_seed, m_pre, m_scan, m_idx, m_seg, m_dig, m_old;
    bit m_prev_step, m_valid, m_wrap, m_tick, m_rise;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 'hACE1; m_seed = 'hACE1; m_pre = 0; m_scan = 0; m_idx = 0;
            m_seg = 0; m_dig = 0; m_prev_step = 0; m_valid = 0; m_wrap = 0;
        end else begin
            m_old  = m_state;
            m_tick = ena && bus.run && (m_pre == 9);
            if (ena && bus.run) m_pre = (m_pre + 1) % 10;
            m_rise = bus.step && !m_prev_step;
            m_prev_step = bus.step;
            if (ena) begin
                m_seg = hex_tab[(m_old >> (4 * m_idx)) % 16];
                m_dig = 1 << m_idx;
                m_scan++;
                if (m_scan == 4) begin
                    m_scan = 0;
                    m_idx = (m_idx + 1) % 4;
                end
            end else begin
                m_seg = 0;
                m_dig = 0;
            end
            m_valid = 0;
            if (ena && bus.seed_load) begin
                m_state = (bus.seed_in == 0) ? 1 : int'(bus.seed_in);
                m_seed = m_state;
                m_wrap = 0;
            end else if (ena && (m_tick || m_rise)) begin
                m_state = lfsr_step(m_state);
                m_valid = 1;
                if (m_state == m_seed) m_wrap = 1;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("rand_out", 32'(bus.rand_out), m_state);
            chk("rand_valid", 32'(bus.rand_valid), 32'(m_valid));
            chk("seg", 32'(bus.seg), m_seg);
            chk("dig_sel", 32'(bus.dig_sel), m_dig);
`ifdef PRNG_WRAP_DET_EN
            chk("wrap_flag", 32'(bus.wrap_flag), 32'(m_wrap));
`else
            chk("wrap_flag", 32'(bus.wrap_flag), 32'(0));
`endif
        end
    end

    task automatic nxt();
        @(negedge clk);
        #2;
    endtask

    int k;
    int seg_codes[4] = '{'h06, 'h79, 'h39, 'h77};
    int small_seq[15] = '{'hC, 'h6, 'h3, 'hD, 'hA, 'h5, 'hE, 'h7, 'hF, 'hB, 'h9, 'h8, 'h4, 'h2, 'h1};

    initial begin
        bus.run = 0; bus.step = 0; bus.seed_load = 0; bus.seed_in = '0;
        sbus.run = 0; sbus.step = 0; sbus.seed_load = 0; sbus.seed_in = '0;
        #12;
        chk("reset_rand_out", 32'(bus.rand_out), 32'hACE1);
        chk("reset_rand_valid", 32'(bus.rand_valid), 32'h0);
        chk("reset_seg", 32'(bus.seg), 32'h00);
        chk("reset_dig_sel", 32'(bus.dig_sel), 32'h0);
        chk("reset_wrap", 32'(bus.wrap_flag), 32'h0);
        chk("small_reset_rand_out", 32'(sbus.rand_out), 32'h1);
        rst_n = 1;
        mon_en = 1;

        // Free-running stepping.
        ena = 1; bus.run = 1;
        for (k = 1; k <= 30; k++) begin nxt(); if (bus.rand_valid) break; end
        chk("first_tick_latency", k, 10);
        chk("first_tick_value", 32'(bus.rand_out), 32'hE270);
        for (k = 1; k <= 30; k++) begin nxt(); if (bus.rand_valid) break; end
        chk("second_tick_latency", k, 10);
        chk("second_tick_value", 32'(bus.rand_out), 32'h7138);
        bus.run = 0;
        repeat (25) nxt();
        chk("run_off_hold", 32'(bus.rand_out), 32'h7138);

        // Zero seed load and single step.
        bus.seed_in = '0; bus.seed_load = 1;
        nxt();
        bus.seed_load = 0;
        chk("zero_seed_load", 32'(bus.rand_out), 32'h0001);
        chk("load_no_valid", 32'(bus.rand_valid), 32'h0);
        bus.step = 1;
        nxt();
        chk("single_step_value", 32'(bus.rand_out), 32'hB400);
        chk("single_step_valid", 32'(bus.rand_valid), 32'h1);
        nxt();
        chk("step_held_no_repeat", 32'(bus.rand_valid), 32'h0);
        bus.step = 0;
        nxt();

        // Load coinciding with a tick and a step edge.
        bus.seed_in = 16'h1234; bus.run = 1;
        for (k = 0; k < 20; k++) begin if (m_pre == 9) break; nxt(); end
        chk("tick_alignment_found", 32'(k < 20), 32'h1);
        bus.seed_load = 1; bus.step = 1;
        nxt();
        chk("load_priority_value", 32'(bus.rand_out), 32'h1234);
        chk("load_priority_valid", 32'(bus.rand_valid), 32'h0);
        bus.seed_load = 0; bus.run = 0;
        nxt();
        chk("discarded_tick", 32'(bus.rand_valid), 32'h0);
        bus.step = 0;
        nxt();

        // Disabled: frozen and blank; step held across enable rising.
        ena = 0; bus.step = 1; bus.seed_load = 1;
        nxt();
        chk("ena_off_seg", 32'(bus.seg), 32'h0);
        chk("ena_off_dig", 32'(bus.dig_sel), 32'h0);
        chk("ena_off_frozen", 32'(bus.rand_out), 32'h1234);
        bus.seed_load = 0;
        nxt();
        ena = 1;
        nxt();
        chk("held_step_on_enable", 32'(bus.rand_out), 32'h1234);
        bus.step = 0;
        nxt();

        // Display scan from a fresh reset.
        ena = 0;
        rst_n = 0;
        nxt();
        rst_n = 1;
        ena = 1;
        for (int j = 0; j < 32; j++) begin
            nxt();
            chk("scan_seg", 32'(bus.seg), seg_codes[(j / 4) % 4]);
            chk("scan_dig", 32'(bus.dig_sel), 32'(1 << ((j / 4) % 4)));
        end
        ena = 0;
        nxt();
        chk("blank_seg", 32'(bus.seg), 32'h0);
        chk("blank_dig", 32'(bus.dig_sel), 32'h0);

        // Asynchronous reset in the middle of a running step.
        ena = 1; bus.run = 1; bus.step = 1;
        repeat (7) nxt();
        #1 rst_n = 0;
        #1;
        chk("async_reset_rand_out", 32'(bus.rand_out), 32'hACE1);
        chk("async_reset_seg", 32'(bus.seg), 32'h0);
        chk("async_reset_valid", 32'(bus.rand_valid), 32'h0);
        ena = 0; bus.run = 0; bus.step = 0;
        nxt();
        rst_n = 1;
        nxt();

        // Small instance: full 15-state period and wrap detection.
        sbus.run = 1; ena_s = 1;
        for (int j = 1; j <= 15; j++) begin
            nxt();
            chk("small_seq", 32'(sbus.rand_out), small_seq[j - 1]);
            chk("small_valid", 32'(sbus.rand_valid), 32'h1);
            if (j == 14) chk("small_wrap_before", 32'(sbus.wrap_flag), 32'h0);
        end
`ifdef PRNG_WRAP_DET_EN
        chk("small_wrap_at_15", 32'(sbus.wrap_flag), 32'h1);
`else
        chk("small_wrap_at_15", 32'(sbus.wrap_flag), 32'h0);
`endif
        chk("small_dig_sel", 32'(sbus.dig_sel), 32'h1);
        ena_s = 0; sbus.run = 0;
        nxt();

        mon_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
